// File: rtl/spi_burst_master.sv
// SPI burst master: one nCS-framed transaction of command, address and 0..MAX_BURST data bytes.
// All four CPOL/CPHA modes; SCLK half-period is CLK_DIV system clocks.
module spi_burst_master #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned LEN_W      = 5,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned CPOL       = 0,
  parameter int unsigned CPHA       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] command,
  input  logic [DATA_WIDTH-1:0] address,
  input  logic [LEN_W-1:0]      burst_len,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk_o,
  output logic                  ncs_o,
  output logic                  mosi_o,
  input  logic                  miso_i
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_BURST);
  localparam logic             SCLK_IDLE = 1'(CPOL);
  localparam logic             SAMPLE_LEAD = (CPHA == 0);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, SHIFT_CMD, SHIFT_ADDR, SHIFT_DATA, CS_HOLD, CS_GAP
  } state_t;

  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic                  half;
  logic [BIT_W-1:0]      bit_cnt;
  logic [LEN_W-1:0]      byte_cnt;
  logic [LEN_W-1:0]      len_q;
  logic [DATA_WIDTH-1:0] cmd_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic                  armed;

  logic                  in_shift_c;
  logic                  half_end_c;
  logic                  sample_c;
  logic [DATA_WIDTH-1:0] load_byte_c;
  logic [DATA_WIDTH-1:0] rx_shift_c;

  // Edge strobes and the byte that the next shift-register load takes
  always_comb begin
    in_shift_c  = 1'b0;
    load_byte_c = tx_data;
    if (state == SHIFT_CMD || state == SHIFT_ADDR || state == SHIFT_DATA) in_shift_c = 1'b1;
    if (state == CS_SETUP) load_byte_c = cmd_q;
    else if (state == SHIFT_CMD) load_byte_c = addr_q;
    half_end_c = (div_cnt == DIV_LAST);
    sample_c   = in_shift_c && half_end_c && (half != SAMPLE_LEAD);
    rx_shift_c = {rx_sr[DATA_WIDTH-2:0], miso_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      half     <= 1'b0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      len_q    <= '0;
      cmd_q    <= '0;
      addr_q   <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      armed    <= 1'b1;
      tx_ready <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sclk_o   <= SCLK_IDLE;
      ncs_o    <= 1'b1;
      mosi_o   <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      done     <= 1'b0;

      if (sample_c) begin
        rx_sr <= rx_shift_c;
        if (state == SHIFT_DATA && bit_cnt == BIT_LAST) begin
          rx_data  <= rx_shift_c;
          rx_valid <= 1'b1;
        end
      end

      case (state)
        // The first IDLE cycle after a transaction ignores start
        IDLE: begin
          if (!armed) begin
            armed <= 1'b1;
          end else if (start) begin
            cmd_q   <= command;
            addr_q  <= address;
            len_q   <= (burst_len > LEN_MAX) ? LEN_MAX : burst_len;
            busy    <= 1'b1;
            ncs_o   <= 1'b0;
            div_cnt <= '0;
            state   <= CS_SETUP;
          end
        end

        CS_SETUP: begin
          if (half_end_c) begin
            div_cnt <= '0;
            half    <= 1'b0;
            bit_cnt <= '0;
            tx_sr   <= SAMPLE_LEAD ? {load_byte_c[DATA_WIDTH-2:0], 1'b0} : load_byte_c;
            if (SAMPLE_LEAD) mosi_o <= load_byte_c[DATA_WIDTH-1];
            state   <= SHIFT_CMD;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        SHIFT_CMD, SHIFT_ADDR, SHIFT_DATA: begin
          if (half_end_c) begin
            div_cnt <= '0;
            sclk_o  <= ~sclk_o;
            half    <= ~half;
            if (!half) begin
              // First edge: CPHA=1 launches the current bit here
              if (!SAMPLE_LEAD) begin
                mosi_o <= tx_sr[DATA_WIDTH-1];
                tx_sr  <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
              end
            end else if (bit_cnt != BIT_LAST) begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              if (SAMPLE_LEAD) begin
                mosi_o <= tx_sr[DATA_WIDTH-1];
                tx_sr  <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
              end
            end else begin
              // Byte boundary: pick the next byte or wind down
              bit_cnt <= '0;
              if (state == SHIFT_DATA && byte_cnt == len_q - LEN_W'(1)) begin
                state <= CS_HOLD;
              end else if (state == SHIFT_ADDR && len_q == '0) begin
                state <= CS_HOLD;
              end else begin
                tx_sr <= SAMPLE_LEAD ? {load_byte_c[DATA_WIDTH-2:0], 1'b0} : load_byte_c;
                if (SAMPLE_LEAD) mosi_o <= load_byte_c[DATA_WIDTH-1];
                if (state == SHIFT_CMD) begin
                  state <= SHIFT_ADDR;
                end else begin
                  tx_ready <= 1'b1;
                  byte_cnt <= (state == SHIFT_ADDR) ? '0 : byte_cnt + LEN_W'(1);
                  state    <= SHIFT_DATA;
                end
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        CS_HOLD: begin
          if (half_end_c) begin
            div_cnt <= '0;
            ncs_o   <= 1'b1;
            mosi_o  <= 1'b0;
            done    <= 1'b1;
            state   <= CS_GAP;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        CS_GAP: begin
          if (half_end_c) begin
            div_cnt <= '0;
            busy    <= 1'b0;
            armed   <= 1'b0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_burst_master.sv
// Bench for spi_burst_master: three mode instances share stimulus; each has its own SPI slave model
// and monitor that check MOSI bytes, RX bytes, framing length and pulse counts against a scoreboard.
module tb_spi_burst_master;

  localparam int unsigned CLK_DIV = 4;
  localparam int BYTE_CYC = 2 * CLK_DIV * 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] command = '0;
  logic [7:0] address = '0;
  logic [7:0] tx_data = '0;
  logic [4:0] burst_len = '0;

  logic [2:0] sclk_w, ncs_w, mosi_w, busy_w, done_w, tx_ready_w, rx_valid_w;
  logic [7:0] rx_data0;

  logic [7:0] tx_bytes   [32];
  logic [7:0] miso_bytes [32];
  logic [7:0] exp_mosi_q [$];
  logic [7:0] exp_rx_q   [$];
  int mosi_base = 0;
  int rx_base   = 0;
  int exp_ncs   = 0;
  int exp_len   = 0;
  int n_checks  = 0;
  int n_pass    = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Slave MISO bit for frame bit i: zeros during command/address, then miso_bytes MSB first
  function automatic logic bitval(input int i);
    logic [7:0] b;
    if (i < 16 || (i - 16) / 8 >= 32) return 1'b0;
    b = miso_bytes[(i - 16) / 8];
    return b[7 - ((i - 16) % 8)];
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_mode
    localparam int unsigned MCPOL = (g == 1) ? 1 : 0;
    localparam int unsigned MCPHA = (g == 0) ? 0 : 1;

    logic       sclk, ncs, mosi, busy, done, tx_ready, rx_valid;
    logic       miso = 1'b0;
    logic [7:0] rx_data;

    spi_burst_master #(
      .DATA_WIDTH(8), .MAX_BURST(16), .LEN_W(5), .CLK_DIV(CLK_DIV),
      .CPOL(MCPOL), .CPHA(MCPHA)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start), .command(command), .address(address),
      .burst_len(burst_len), .tx_data(tx_data), .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .busy(busy), .done(done), .sclk_o(sclk), .ncs_o(ncs),
      .mosi_o(mosi), .miso_i(miso)
    );

    assign sclk_w[g]     = sclk;
    assign ncs_w[g]      = ncs;
    assign mosi_w[g]     = mosi;
    assign busy_w[g]     = busy;
    assign done_w[g]     = done;
    assign tx_ready_w[g] = tx_ready;
    assign rx_valid_w[g] = rx_valid;
    if (g == 0) begin : g_rx0
      assign rx_data0 = rx_data;
    end

    bit         in_txn = 1'b0;
    logic       prev_sclk = 1'b0;
    int         ncs_cnt, bitn, obit, mrd, rrd, txr, last_rx;
    logic [7:0] sh;

    // Slave model plus monitor, evaluated away from the active edge
    always @(negedge clk) begin
      logic [7:0] nb;
      if (rst) begin
        in_txn = 1'b0;
        miso   = 1'b0;
      end else if (!in_txn && !ncs) begin
        in_txn  = 1'b1;
        ncs_cnt = 1;
        bitn    = 0;
        sh      = '0;
        txr     = 0;
        last_rx = -1;
        mrd     = mosi_base;
        rrd     = rx_base;
        chk($sformatf("m%0d sclk_idle_at_cs", g), sclk, MCPOL);
        if (MCPHA == 0) begin miso = bitval(0); obit = 1; end
        else begin miso = 1'b0; obit = 0; end
      end else if (in_txn && !ncs) begin
        ncs_cnt++;
        if (sclk != prev_sclk) begin
          if ((sclk != 1'(MCPOL)) == (MCPHA == 0)) begin
            nb   = {sh[6:0], mosi};
            sh   = nb;
            bitn++;
            if (bitn % 8 == 0) begin
              if (mrd < exp_mosi_q.size()) chk($sformatf("m%0d mosi_byte%0d", g, mrd - mosi_base), nb, exp_mosi_q[mrd]);
              else chk($sformatf("m%0d mosi_extra_byte", g), nb, 9'h100);
              mrd++;
            end
          end else begin
            miso = bitval(obit);
            obit++;
          end
        end
        if (rx_valid) begin
          if (rrd < exp_rx_q.size()) chk($sformatf("m%0d rx_data%0d", g, rrd - rx_base), rx_data, exp_rx_q[rrd]);
          else chk($sformatf("m%0d rx_extra", g), rx_data, 9'h100);
          if (last_rx >= 0) chk($sformatf("m%0d rx_spacing", g), ncs_cnt - last_rx, BYTE_CYC);
          last_rx = ncs_cnt;
          rrd++;
        end
        if (tx_ready) txr++;
      end else if (in_txn && ncs) begin
        in_txn = 1'b0;
        chk($sformatf("m%0d ncs_low_cycles", g), ncs_cnt, exp_ncs);
        chk($sformatf("m%0d done_with_cs_rise", g), done, 1);
        chk($sformatf("m%0d sclk_idle_at_end", g), sclk, MCPOL);
        chk($sformatf("m%0d mosi_byte_count", g), mrd - mosi_base, exp_mosi_q.size() - mosi_base);
        chk($sformatf("m%0d rx_valid_count", g), rrd - rx_base, exp_rx_q.size() - rx_base);
        chk($sformatf("m%0d tx_ready_count", g), txr, exp_len);
      end
      prev_sclk = sclk;
    end
  end

  task automatic expect_txn(input logic [7:0] cmd, input logic [7:0] addr, input int len);
    int eff;
    eff = (len > 16) ? 16 : len;
    mosi_base = exp_mosi_q.size();
    rx_base   = exp_rx_q.size();
    exp_mosi_q.push_back(cmd);
    exp_mosi_q.push_back(addr);
    for (int i = 0; i < eff; i++) exp_mosi_q.push_back(tx_bytes[i]);
    for (int i = 0; i < eff; i++) exp_rx_q.push_back(miso_bytes[i]);
    exp_ncs = 2 * CLK_DIV + BYTE_CYC * (2 + eff);
    exp_len = eff;
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [7:0] addr, input int len, input bit hold);
    int k;
    int c;
    bit bad;
    expect_txn(cmd, addr, len);
    @(negedge clk);
    command   = cmd;
    address   = addr;
    burst_len = 5'(len);
    tx_data   = tx_bytes[0];
    start     = 1'b1;
    @(negedge clk);
    chk("accept_busy", busy_w, 3'b111);
    chk("accept_ncs", ncs_w, 3'b000);
    if (!hold) start = 1'b0;
    k = 0;
    c = 0;
    while (!done_w[0] && c < 5000) begin
      if (tx_ready_w[0]) begin
        k++;
        tx_data = (k < 32) ? tx_bytes[k] : 8'h00;
      end
      @(negedge clk);
      c++;
    end
    chk("done_all", done_w, 3'b111);
    start = 1'b0;
    c = 0;
    while (busy_w[0] && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("busy_fall_after_done", c, CLK_DIV);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy_w != 3'b000 || ncs_w != 3'b111) bad = 1'b1;
    end
    chk("quiet_after_txn", bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int i = 0; i < 32; i++) begin
      tx_bytes[i]   = 8'h00;
      miso_bytes[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ncs", ncs_w, 3'b111);
    chk("reset_sclk", sclk_w, 3'b010);
    chk("reset_mosi", mosi_w, 3'b000);
    chk("reset_busy", busy_w, 3'b000);
    chk("reset_done", done_w, 3'b000);
    chk("reset_tx_ready", tx_ready_w, 3'b000);
    chk("reset_rx_valid", rx_valid_w, 3'b000);
    chk("reset_rx_data", rx_data0, 8'h00);

    // Single-byte read
    miso_bytes[0] = 8'hAD;
    run_txn(8'h0B, 8'h00, 1, 1'b0);

    // Single-byte write
    tx_bytes[0] = 8'h02;
    miso_bytes[0] = 8'h77;
    run_txn(8'h0A, 8'h2D, 1, 1'b0);

    // Four-byte burst read
    tx_bytes[0] = 8'h00;
    miso_bytes[0] = 8'hAD; miso_bytes[1] = 8'h1D; miso_bytes[2] = 8'hF2; miso_bytes[3] = 8'h01;
    run_txn(8'h0B, 8'h00, 4, 1'b0);

    // Zero-length burst
    run_txn(8'h0B, 8'h02, 0, 1'b0);

    // Over-long burst is clamped to 16 bytes
    for (int i = 0; i < 32; i++) begin
      tx_bytes[i]   = 8'(i * 3 + 1);
      miso_bytes[i] = 8'(i * 17 + 5);
    end
    run_txn(8'h0B, 8'h00, 31, 1'b0);

    // start held high throughout
    tx_bytes[0] = 8'h55;
    miso_bytes[0] = 8'hC3;
    run_txn(8'h0A, 8'h1F, 1, 1'b1);

    // Asynchronous reset in the middle of the data phase
    tx_bytes[0] = 8'hE1; tx_bytes[1] = 8'h2B;
    miso_bytes[0] = 8'h3C; miso_bytes[1] = 8'h96;
    expect_txn(8'h0B, 8'h0E, 2);
    @(negedge clk);
    command = 8'h0B; address = 8'h0E; burst_len = 5'd2; tx_data = tx_bytes[0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (!tx_ready_w[0] && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("reached_data_phase", tx_ready_w[0], 1);
    tx_data = tx_bytes[1];
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ncs", ncs_w, 3'b111);
    chk("async_rst_sclk", sclk_w, 3'b010);
    chk("async_rst_busy", busy_w, 3'b000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(8'h0B, 8'h0E, 2, 1'b0);

    // Mode sweep pattern
    miso_bytes[0] = 8'h5A;
    tx_bytes[0] = 8'h00;
    run_txn(8'h0B, 8'h08, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
